// File: rtl/stack_ctrl.sv
// Operand-stack sequencer: owns the LIFO storage and stack pointer, and turns
// one-cycle push/pop/tos strobes into busy/done handshaked read/write sequences.
module stack_ctrl #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          tos_i,
  input  logic [DW-1:0] din_i,
  input  logic          clr_err_i,
  output logic [DW-1:0] dout_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o,
  output logic          err_ovf_o,
  output logic          err_unf_o,
  output logic          err_cmd_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PUSH,
    S_READ,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   sp_q, sp_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_unf_q, err_unf_d;
  logic          err_cmd_q, err_cmd_d;
  logic          set_ovf, set_unf, set_cmd;
  logic          empty, full;

  logic [DW-1:0] mem_q [DEPTH];

  assign empty = (sp_q == '0);
  assign full  = (sp_q == (AW+1)'(DEPTH));

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    raddr_d = raddr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    set_cmd = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Priority decode; failed commands skip straight to DONE so they still pulse done.
        if (push_i && pop_i) begin
          set_cmd = 1'b1;
          state_d = S_DONE;
        end else if (push_i && full) begin
          set_ovf = 1'b1;
          state_d = S_DONE;
        end else if (push_i) begin
          wdata_d = din_i;
          state_d = S_PUSH;
        end else if (pop_i && empty) begin
          set_unf = 1'b1;
          state_d = S_DONE;
        end else if (pop_i) begin
          sp_d    = sp_q - (AW+1)'(1);
          raddr_d = AW'(sp_q - (AW+1)'(1));
          state_d = S_READ;
        end else if (tos_i && empty) begin
          set_unf = 1'b1;
          state_d = S_DONE;
        end else if (tos_i) begin
          raddr_d = AW'(sp_q - (AW+1)'(1));
          state_d = S_READ;
        end
      end
      S_PUSH: begin
        sp_d    = sp_q + (AW+1)'(1);
        state_d = S_DONE;
      end
      S_READ: begin
        dout_d  = mem_q[raddr_q];
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Set wins over a simultaneous clear.
  assign err_ovf_d = set_ovf | (err_ovf_q & ~clr_err_i);
  assign err_unf_d = set_unf | (err_unf_q & ~clr_err_i);
  assign err_cmd_d = set_cmd | (err_cmd_q & ~clr_err_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      sp_q      <= '0;
      raddr_q   <= '0;
      wdata_q   <= '0;
      dout_q    <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      err_cmd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      raddr_q   <= raddr_d;
      wdata_q   <= wdata_d;
      dout_q    <= dout_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      err_cmd_q <= err_cmd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == S_PUSH) begin
      mem_q[sp_q[AW-1:0]] <= wdata_q;
    end
  end

  assign dout_o    = dout_q;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign empty_o   = empty;
  assign full_o    = full;
  assign count_o   = sp_q;
  assign err_ovf_o = err_ovf_q;
  assign err_unf_o = err_unf_q;
  assign err_cmd_o = err_cmd_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl: a vector table of single commands plus
// hand-written sequences for reset, overflow, busy strobes and throughput.
module tb_stack_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       push_i, pop_i, tos_i, clr_err_i;
  logic [7:0] din_i;
  logic [7:0] dout_o;
  logic       busy_o, done_o, empty_o, full_o;
  logic [4:0] count_o;
  logic       err_ovf_o, err_unf_o, err_cmd_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  stack_ctrl #(.DW(8), .DEPTH(16)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (push_i),
    .pop_i     (pop_i),
    .tos_i     (tos_i),
    .din_i     (din_i),
    .clr_err_i (clr_err_i),
    .dout_o    (dout_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .empty_o   (empty_o),
    .full_o    (full_o),
    .count_o   (count_o),
    .err_ovf_o (err_ovf_o),
    .err_unf_o (err_unf_o),
    .err_cmd_o (err_cmd_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  typedef struct {
    logic       pu, po, to, cl;
    logic [7:0] din;
    int         lat;
    logic [7:0] dout;
    logic [4:0] count;
    logic       ovf, unf, cmd, empty, full;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command from IDLE; returns edges from E0 to done and the outputs
  // seen while done is high, then steps one more edge and checks done dropped.
  task automatic run_op(input logic pu, input logic po, input logic to, input logic cl,
                        input logic [7:0] d, output int lat, output logic [7:0] s_dout,
                        output logic [4:0] s_count, output logic [2:0] s_err,
                        output logic [1:0] s_ef);
    push_i = pu; pop_i = po; tos_i = to; clr_err_i = cl; din_i = d;
    @(posedge clk_i); #1;
    push_i = 0; pop_i = 0; tos_i = 0; clr_err_i = 0;
    lat = 1;
    while (!done_o && lat < 8) begin
      @(posedge clk_i); #1;
      lat++;
    end
    s_dout  = dout_o;
    s_count = count_o;
    s_err   = {err_ovf_o, err_unf_o, err_cmd_o};
    s_ef    = {empty_o, full_o};
    @(posedge clk_i); #1;
    chk("done_single_pulse", done_o, 1'b0);
  endtask

  task automatic clear_errs();
    clr_err_i = 1;
    @(posedge clk_i); #1;
    clr_err_i = 0;
  endtask

  initial begin
    int         lat, c0;
    logic [7:0] s_dout;
    logic [4:0] s_count;
    logic [2:0] s_err;
    logic [1:0] s_ef;

    //           pu po to cl din    lat dout   cnt ovf unf cmd emp full
    vecs[0]  = '{1, 0, 0, 0, 8'h11, 2, 8'h00, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 8'h22, 2, 8'h00, 2, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 8'h33, 2, 8'h00, 3, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 8'h00, 2, 8'h33, 2, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 0, 8'h00, 2, 8'h22, 2, 0, 0, 0, 0, 0};
    vecs[5]  = '{0, 1, 0, 0, 8'h00, 2, 8'h22, 1, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 1, 0, 0, 8'h00, 2, 8'h11, 0, 0, 0, 0, 1, 0};
    vecs[7]  = '{0, 1, 0, 0, 8'h00, 1, 8'h11, 0, 0, 1, 0, 1, 0};
    vecs[8]  = '{0, 1, 0, 1, 8'h00, 1, 8'h11, 0, 0, 1, 0, 1, 0};
    vecs[9]  = '{1, 1, 0, 0, 8'hEE, 1, 8'h11, 0, 0, 1, 1, 1, 0};
    vecs[10] = '{1, 0, 1, 0, 8'h5A, 2, 8'h11, 1, 0, 1, 1, 0, 0};
    vecs[11] = '{0, 0, 1, 0, 8'h00, 2, 8'h5A, 1, 0, 1, 1, 0, 0};

    rst_ni = 0; push_i = 0; pop_i = 0; tos_i = 0; clr_err_i = 0; din_i = '0;
    #12;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_count", count_o, 5'd0);
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_full", full_o, 1'b0);
    chk("rst_errs", {err_ovf_o, err_unf_o, err_cmd_o}, 3'b000);
    @(posedge clk_i); #1;
    rst_ni = 1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].pu, vecs[i].po, vecs[i].to, vecs[i].cl, vecs[i].din,
             lat, s_dout, s_count, s_err, s_ef);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_dout", i), s_dout, vecs[i].dout);
      chk($sformatf("v%0d_count", i), s_count, vecs[i].count);
      chk($sformatf("v%0d_errs", i), s_err, {vecs[i].ovf, vecs[i].unf, vecs[i].cmd});
      chk($sformatf("v%0d_empty_full", i), s_ef, {vecs[i].empty, vecs[i].full});
    end

    clear_errs();
    chk("clr_alone", {err_ovf_o, err_unf_o, err_cmd_o}, 3'b000);

    // Drain the single remaining entry, then fill to capacity.
    run_op(0, 1, 0, 0, 8'h00, lat, s_dout, s_count, s_err, s_ef);
    chk("drain_dout", s_dout, 8'h5A);
    for (int i = 0; i < 16; i++) begin
      run_op(1, 0, 0, 0, 8'(i), lat, s_dout, s_count, s_err, s_ef);
    end
    chk("fill_count", count_o, 5'd16);
    chk("fill_full", full_o, 1'b1);
    run_op(1, 0, 0, 0, 8'hAA, lat, s_dout, s_count, s_err, s_ef);
    chk("ovf_lat", lat, 1);
    chk("ovf_flag", s_err, 3'b100);
    chk("ovf_count", s_count, 5'd16);
    run_op(0, 1, 0, 0, 8'h00, lat, s_dout, s_count, s_err, s_ef);
    chk("ovf_pop_dout", s_dout, 8'h0F);
    chk("ovf_pop_count", s_count, 5'd15);

    // Reset pulse while in PUSH.
    push_i = 1; din_i = 8'h99;
    @(posedge clk_i); #1;
    push_i = 0;
    chk("mid_push_busy", busy_o, 1'b1);
    #2 rst_ni = 0;
    #1;
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_count", count_o, 5'd0);
    chk("mid_rst_dout", dout_o, 8'h00);
    chk("mid_rst_flags", {err_ovf_o, err_unf_o, err_cmd_o}, 3'b000);
    chk("mid_rst_empty_full", {empty_o, full_o}, 2'b10);
    @(posedge clk_i); #1;
    rst_ni = 1;
    run_op(0, 1, 0, 0, 8'h00, lat, s_dout, s_count, s_err, s_ef);
    chk("post_rst_unf", s_err, 3'b010);
    chk("post_rst_count", s_count, 5'd0);
    clear_errs();

    // Pop strobe held through PUSH and DONE must be ignored.
    push_i = 1; din_i = 8'h77;
    @(posedge clk_i); #1;
    push_i = 0; pop_i = 1;
    @(posedge clk_i); #1;
    chk("busy_pop_done", done_o, 1'b1);
    @(posedge clk_i); #1;
    pop_i = 0;
    chk("busy_pop_count", count_o, 5'd1);
    chk("busy_pop_flags", {err_ovf_o, err_unf_o, err_cmd_o}, 3'b000);
    run_op(0, 0, 1, 0, 8'h00, lat, s_dout, s_count, s_err, s_ef);
    chk("busy_pop_tos", s_dout, 8'h77);

    // Back-to-back alternating pairs at peak throughput.
    c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      run_op(1, 0, 0, 0, 8'hA0 + 8'(i), lat, s_dout, s_count, s_err, s_ef);
      chk($sformatf("b2b%0d_push_count", i), s_count, 5'd2);
      run_op(0, 1, 0, 0, 8'h00, lat, s_dout, s_count, s_err, s_ef);
      chk($sformatf("b2b%0d_pop_dout", i), s_dout, 8'hA0 + 8'(i));
    end
    chk("b2b_cycles", cyc - c0, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
